// File: rtl/cdb_slot_arbiter_pkg.sv
// Shared CDB widths, default FU map and latency helpers for the CDB slot arbiter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package cdb_slot_arbiter_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;

  // Default execution unit indices
  localparam int FU_LS   = 0;
  localparam int FU_MULT = 1;
  localparam int FU_DIV  = 2;
  localparam int FU_INT  = 3;

  localparam int          DEF_NUM_FU  = 4;
  localparam int          DEF_MAX_LAT = 8;
  localparam logic [15:0] DEF_FU_LAT  = {4'd1, 4'd6, 4'd3, 4'd1};
  localparam logic [3:0]  DEF_FU_PIPE = 4'b1011;

  // Registered CDB status flags
  typedef struct packed {
    logic vld;
    logic branch;
    logic taken;
  } cdb_ctl_t;

  // Latency of FU 'fu' from the packed 4-bit-per-FU latency vector
  function automatic int lat_of(logic [31:0] lat_vec, int fu);
    return int'(lat_vec[4*fu +: 4]);
  endfunction

endpackage

// File: rtl/cdb_slot_arbiter_rr_pick.sv
// Round-robin first-one finder: first set req bit at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; gnt is one-hot (or zero when no request).
// Ports: req  - request vector
//        ptr  - search start index
//        gnt  - one-hot winner
//        idx  - winner index
//        any  - at least one request present
module cdb_slot_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Offset j walks the ring starting at ptr; the first hit wins.
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (((int'(ptr) + j) % N) == i)) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_slot_arbiter.sv
// CDB reservation arbiter + registered writeback mux for NUM_FU fixed-latency FUs.
// Latency: grant in cycle t, FU result sampled in t+L, CDB outputs valid in t+L+1.
// Backpressure: FUs are held off (no fu_grant) while their CDB slot is taken, while a
//   blocking FU is busy, during cdb_flush, and while reset is asserted.
// Ports: clk/reset (async, active-low); fu_ready -> fu_grant issue handshake;
//   fu_result_* per-FU result buses; cdb_flush cancels in-flight reservations;
//   cdb_* registered broadcast to reservation stations / ROB.
module cdb_slot_arbiter
  import cdb_slot_arbiter_pkg::*;
#(
  parameter int                  NUM_FU  = DEF_NUM_FU,
  parameter int                  DATA_W  = CDB_DATA_W,
  parameter int                  TAG_W   = CDB_TAG_W,
  parameter int                  MAX_LAT = DEF_MAX_LAT,
  parameter logic [4*NUM_FU-1:0] FU_LAT  = DEF_FU_LAT,
  parameter logic [NUM_FU-1:0]   FU_PIPE = DEF_FU_PIPE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        fu_grant,
  input  logic [NUM_FU*DATA_W-1:0] fu_result_data,
  input  logic [NUM_FU*TAG_W-1:0]  fu_result_tag,
  input  logic [NUM_FU-1:0]        fu_result_branch,
  input  logic [NUM_FU-1:0]        fu_result_taken,
  input  logic [NUM_FU-1:0]        fu_result_nowb,
  input  logic                     cdb_flush,
  output logic                     cdb_valid,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic                     cdb_branch,
  output logic                     cdb_branch_taken
);

  localparam int          IDX_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int          BUSY_W  = $clog2(MAX_LAT + 1);
  localparam logic [31:0] LAT_VEC = 32'(FU_LAT);

  // occ_r[1] marks the slot whose owner drives its result this cycle; occ_r[k] the
  // slot driven k-1 cycles from now. A new grant at latency L lands in occ_r[L], so it
  // collides with whatever currently sits in occ_r[L+1].
  logic [MAX_LAT:1]   occ_r;
  logic [IDX_W-1:0]   own_r   [1:MAX_LAT];
  logic [MAX_LAT+1:1] occ_ext;
  logic [IDX_W-1:0]   own_ext [1:MAX_LAT+1];
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_FU-1:0]  elig;
  logic [NUM_FU-1:0]  idle;

  assign occ_ext = {1'b0, occ_r};

  always_comb begin
    for (int k = 1; k <= MAX_LAT; k++) own_ext[k] = own_r[k];
    own_ext[MAX_LAT+1] = '0;
  end

  // Per-FU eligibility and blocking-FU busy counter
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    localparam int LAT  = lat_of(LAT_VEC, i);
    localparam int SLOT = (LAT >= 1 && LAT <= MAX_LAT) ? LAT + 1 : MAX_LAT + 1;
    logic [BUSY_W-1:0] busy_cnt;

    if (LAT < 1 || LAT > MAX_LAT) begin : g_bad_lat
      $error("cdb_slot_arbiter: FU %0d latency %0d outside 1..%0d", i, LAT, MAX_LAT);
    end

    assign idle[i] = FU_PIPE[i] | (busy_cnt == '0);
    assign elig[i] = reset & fu_ready[i] & ~cdb_flush & ~occ_ext[SLOT] & idle[i];

    // Loading L-1 lets the FU re-issue in the very cycle its previous result returns.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        busy_cnt <= '0;
      end else if (cdb_flush) begin
        busy_cnt <= '0;
      end else if (fu_grant[i] && !FU_PIPE[i]) begin
        busy_cnt <= BUSY_W'(LAT - 1);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BUSY_W'(1);
      end
    end
  end

  // One round-robin picker per latency group; distinct groups never collide.
  logic [NUM_FU-1:0] grp_req  [1:MAX_LAT];
  logic [NUM_FU-1:0] grp_gnt  [1:MAX_LAT];
  logic [IDX_W-1:0]  grp_idx  [1:MAX_LAT];
  logic              grp_any  [1:MAX_LAT];
  logic              grp_conf [1:MAX_LAT];

  for (genvar l = 1; l <= MAX_LAT; l++) begin : g_lat
    for (genvar i = 0; i < NUM_FU; i++) begin : g_mem
      assign grp_req[l][i] = elig[i] & (lat_of(LAT_VEC, i) == l);
    end
    // More than one bit set
    assign grp_conf[l] = (grp_req[l] & (grp_req[l] - NUM_FU'(1))) != '0;

    cdb_slot_arbiter_rr_pick #(
      .N     (NUM_FU),
      .IDX_W (IDX_W)
    ) u_pick (
      .req (grp_req[l]),
      .ptr (rr_ptr),
      .gnt (grp_gnt[l]),
      .idx (grp_idx[l]),
      .any (grp_any[l])
    );
  end

  // Merge group grants. A single shared pointer advances past the winner of the
  // lowest-latency conflicting group when several groups conflict at once.
  logic             conf_hit;
  logic [IDX_W-1:0] conf_idx;

  always_comb begin
    fu_grant = '0;
    conf_hit = 1'b0;
    conf_idx = '0;
    for (int l = 1; l <= MAX_LAT; l++) begin
      fu_grant = fu_grant | grp_gnt[l];
      if (grp_conf[l] && !conf_hit) begin
        conf_hit = 1'b1;
        conf_idx = grp_idx[l];
      end
    end
  end

  // Reservation / owner shift register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_r  <= '0;
      rr_ptr <= '0;
      for (int k = 1; k <= MAX_LAT; k++) own_r[k] <= '0;
    end else begin
      if (cdb_flush) begin
        occ_r <= '0;
        for (int k = 1; k <= MAX_LAT; k++) own_r[k] <= '0;
      end else begin
        // Eligibility already excludes a grant landing on an occupied slot.
        for (int k = 1; k <= MAX_LAT; k++) begin
          occ_r[k] <= occ_ext[k+1] | grp_any[k];
          own_r[k] <= grp_any[k] ? grp_idx[k] : own_ext[k+1];
        end
      end
      if (conf_hit) begin
        rr_ptr <= (conf_idx == IDX_W'(NUM_FU - 1)) ? '0 : conf_idx + IDX_W'(1);
      end
    end
  end

  // Owner result select
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_br;
  logic              sel_tk;
  logic              sel_nowb;

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    sel_br   = 1'b0;
    sel_tk   = 1'b0;
    sel_nowb = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (own_r[1] == IDX_W'(i)) begin
        sel_data = fu_result_data[i*DATA_W +: DATA_W];
        sel_tag  = fu_result_tag[i*TAG_W +: TAG_W];
        sel_br   = fu_result_branch[i];
        sel_tk   = fu_result_taken[i];
        sel_nowb = fu_result_nowb[i];
      end
    end
  end

  // Registered CDB. Loads from occ_r[1] even during a flush: that result was already
  // committed to this cycle before the flush arrived.
  cdb_ctl_t ctl_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_r    <= '0;
      cdb_data <= '0;
      cdb_tag  <= '0;
    end else if (!occ_r[1]) begin
      ctl_r    <= '0;
      cdb_data <= '0;
      cdb_tag  <= '0;
    end else if (sel_br) begin
      ctl_r    <= '{vld: 1'b0, branch: 1'b1, taken: sel_tk};
      cdb_data <= '0;
      cdb_tag  <= '0;
    end else if (sel_nowb) begin
      ctl_r    <= '{vld: 1'b1, branch: 1'b0, taken: 1'b0};
      cdb_data <= '0;
      cdb_tag  <= '0;
    end else begin
      ctl_r    <= '{vld: 1'b1, branch: 1'b0, taken: 1'b0};
      cdb_data <= sel_data;
      cdb_tag  <= sel_tag;
    end
  end

  assign cdb_valid        = ctl_r.vld;
  assign cdb_branch       = ctl_r.branch;
  assign cdb_branch_taken = ctl_r.taken;

endmodule

// File: tb/tb_cdb_slot_arbiter.sv
// Self-checking bench for cdb_slot_arbiter with default parameters.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_cdb_slot_arbiter;
  import cdb_slot_arbiter_pkg::*;

  localparam int NFU = DEF_NUM_FU;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [NFU-1:0]  fu_ready = '0;
  logic [NFU-1:0]  fu_grant;
  logic [31:0]     d  [NFU];
  logic [5:0]      tg [NFU];
  logic [NFU-1:0]  br   = '0;
  logic [NFU-1:0]  tk   = '0;
  logic [NFU-1:0]  nowb = '0;
  logic            flush = 1'b0;
  logic [NFU*32-1:0] rd;
  logic [NFU*6-1:0]  rt;
  logic            cdb_valid;
  logic [31:0]     cdb_data;
  logic [5:0]      cdb_tag;
  logic            cdb_branch;
  logic            cdb_branch_taken;

  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic mon_en      = 1'b0;

  typedef struct {
    int          cyc;
    logic        vld;
    logic [31:0] dat;
    logic [5:0]  tag;
    logic        br;
    logic        tk;
    logic        care;
  } exp_t;

  exp_t sb[$];

  assign rd = {d[3], d[2], d[1], d[0]};
  assign rt = {tg[3], tg[2], tg[1], tg[0]};

  cdb_slot_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .fu_ready         (fu_ready),
    .fu_grant         (fu_grant),
    .fu_result_data   (rd),
    .fu_result_tag    (rt),
    .fu_result_branch (br),
    .fu_result_taken  (tk),
    .fu_result_nowb   (nowb),
    .cdb_flush        (flush),
    .cdb_valid        (cdb_valid),
    .cdb_data         (cdb_data),
    .cdb_tag          (cdb_tag),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(int at, logic v, logic [31:0] dd, logic [5:0] tt,
                      logic b, logic t, logic care);
    exp_t e;
    e.cyc = at; e.vld = v; e.dat = dd; e.tag = tt; e.br = b; e.tk = t; e.care = care;
    sb.push_back(e);
  endtask

  // Scoreboard: every cycle the CDB must match the due entry, or be idle (all zero).
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      e.cyc = cyc; e.vld = 1'b0; e.dat = '0; e.tag = '0; e.br = 1'b0; e.tk = 1'b0; e.care = 1'b1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL cdb_missed entry due cyc %0d never matched (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
      vectors++;
      if (cdb_valid !== e.vld || cdb_branch !== e.br || cdb_branch_taken !== e.tk ||
          (e.care && (cdb_data !== e.dat || cdb_tag !== e.tag))) begin
        miscompares++;
        $display("FAIL cdb_out cyc %0d got v=%b d=%h t=%0d b=%b k=%b want v=%b d=%h t=%0d b=%b k=%b",
                 cyc, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken,
                 e.vld, e.dat, e.tag, e.br, e.tk);
      end
    end
  end

  task automatic test_reset();
    fu_ready = '1;
    #1 reset = 1'b0;
    tick(); tick(); #1;
    vectors++;
    if ({fu_grant, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got g=%b v=%b d=%h t=%0d b=%b k=%b want all zero",
               fu_grant, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken);
    end
    fu_ready = '0;
    reset    = 1'b1;
    mon_en   = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    tick(); fu_ready = 4'b1010; #1;
    vectors++;
    if (fu_grant !== 4'b1010) begin
      miscompares++;
      $display("FAIL rstmid_grant got %b want %b", fu_grant, 4'b1010);
    end
    push(cyc + 2, 1'b1, d[FU_INT], tg[FU_INT], 1'b0, 1'b0, 1'b1);
    tick(); fu_ready = '0; #1;
    vectors++;
    if (fu_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_idle_grant got %b want %b", fu_grant, 4'b0000);
    end
    tick(); fu_ready = 4'b0010;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({fu_grant, cdb_valid, cdb_data, cdb_tag, cdb_branch, cdb_branch_taken} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear got g=%b v=%b d=%h t=%0d want all zero",
               fu_grant, cdb_valid, cdb_data, cdb_tag);
    end
    tick(); reset = 1'b1; fu_ready = '0;
    repeat (6) tick();
  endtask

  task automatic test_distinct_lat();
    logic [3:0] rs [5];
    logic [3:0] gs [5];
    rs = '{4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    gs = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      tick(); fu_ready = rs[k]; #1;
      vectors++;
      if (fu_grant !== gs[k]) begin
        miscompares++;
        $display("FAIL dist_lat_grant step %0d got %b want %b", k, fu_grant, gs[k]);
      end
      if (k == 0) push(cyc + 4, 1'b1, d[FU_MULT], tg[FU_MULT], 1'b0, 1'b0, 1'b1);
      if (k == 3) push(cyc + 2, 1'b1, d[FU_INT], tg[FU_INT], 1'b0, 1'b0, 1'b1);
    end
    repeat (6) tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] gs [5];
    gs = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      tick(); fu_ready = (k < 4) ? 4'b1001 : 4'b0000; #1;
      vectors++;
      if (fu_grant !== gs[k]) begin
        miscompares++;
        $display("FAIL rr_grant step %0d got %b want %b", k, fu_grant, gs[k]);
      end
      if (k < 4) begin
        if (k % 2 == 0) push(cyc + 2, 1'b1, d[FU_LS], tg[FU_LS], 1'b0, 1'b0, 1'b1);
        else            push(cyc + 2, 1'b1, d[FU_INT], tg[FU_INT], 1'b0, 1'b0, 1'b1);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_blocking_div();
    logic [3:0] want;
    for (int k = 0; k < 9; k++) begin
      tick(); fu_ready = (k < 8) ? 4'b0100 : 4'b0000; #1;
      want = (k == 0 || k == 6) ? 4'b0100 : 4'b0000;
      vectors++;
      if (fu_grant !== want) begin
        miscompares++;
        $display("FAIL div_grant step %0d got %b want %b", k, fu_grant, want);
      end
      if (k == 0 || k == 6) push(cyc + 7, 1'b1, 32'h64, 6'd3, 1'b0, 1'b0, 1'b1);
    end
    repeat (6) tick();
  endtask

  task automatic test_branch_store();
    br[FU_INT] = 1'b1; tk[FU_INT] = 1'b1; nowb[FU_LS] = 1'b1;
    tick(); fu_ready = 4'b1000; #1;
    vectors++;
    if (fu_grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL branch_grant got %b want %b", fu_grant, 4'b1000);
    end
    push(cyc + 2, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    tick(); fu_ready = 4'b0001; #1;
    vectors++;
    if (fu_grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL store_grant got %b want %b", fu_grant, 4'b0001);
    end
    push(cyc + 2, 1'b1, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1);
    tick(); fu_ready = '0;
    repeat (4) tick();
    br = '0; tk = '0; nowb = '0;
  endtask

  task automatic test_flush();
    logic [3:0] rs [4];
    logic [3:0] gs [4];
    rs = '{4'b1110, 4'b1110, 4'b0100, 4'b0000};
    gs = '{4'b1110, 4'b0000, 4'b0100, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      tick(); fu_ready = rs[k]; flush = (k == 1); #1;
      vectors++;
      if (fu_grant !== gs[k]) begin
        miscompares++;
        $display("FAIL flush_grant step %0d got %b want %b", k, fu_grant, gs[k]);
      end
      // INT's result is driven in the flush cycle itself and must still reach the CDB;
      // MULT and the first DIV are cancelled.
      if (k == 0) push(cyc + 2, 1'b1, d[FU_INT], tg[FU_INT], 1'b0, 1'b0, 1'b1);
      if (k == 2) push(cyc + 7, 1'b1, d[FU_DIV], tg[FU_DIV], 1'b0, 1'b0, 1'b1);
    end
    flush = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    d[FU_LS]   = 32'h0000_00A0; tg[FU_LS]   = 6'd10;
    d[FU_MULT] = 32'h0000_00B1; tg[FU_MULT] = 6'd5;
    d[FU_DIV]  = 32'h0000_0064; tg[FU_DIV]  = 6'd3;
    d[FU_INT]  = 32'h0000_00D3; tg[FU_INT]  = 6'd9;

    test_reset();
    test_reset_mid();
    test_distinct_lat();
    test_round_robin();
    test_blocking_div();
    test_branch_store();
    test_flush();

    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d pending entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
